// File: rtl/mul_issue_ctrl_if.sv
// Handshake bundle between the EX-stage issue controller and the 6-cycle HI/LO multiplier.
// Operands and signed hold stable while start=1; ready pulses one cycle; start drops in that cycle.
interface mul_issue_ctrl_if #(
  parameter int W = 32
);
  logic           mul_signed;
  logic [W-1:0]   mul_op1;
  logic [W-1:0]   mul_op2;
  logic           mul_start;
  logic [2*W-1:0] mul_result;
  logic           mul_ready;

  modport master (
    output mul_signed, mul_op1, mul_op2, mul_start,
    input  mul_result, mul_ready
  );

  modport slave (
    input  mul_signed, mul_op1, mul_op2, mul_start,
    output mul_result, mul_ready
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// EX-stage initiator for the HI/LO multiplier: decodes MULT/MADD/MSUB variants, stalls while
// the multiply runs, applies the accumulate and issues a single HI/LO write.
module mul_issue_ctrl #(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           op_i,
  input  logic [W-1:0]         opdata1_i,
  input  logic [W-1:0]         opdata2_i,
  input  logic [W-1:0]         hi_i,
  input  logic [W-1:0]         lo_i,
  input  logic                 flush_i,
  mul_issue_ctrl_if.master     mul,
  output logic                 stallreq_o,
  output logic                 whilo_o,
  output logic [W-1:0]         hi_o,
  output logic [W-1:0]         lo_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MADD  = 3'd3;
  localparam logic [2:0] OP_MADDU = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MSUBU = 3'd6;

  state_t         r_state;
  state_t         w_next;
  acc_t           r_mode;
  acc_t           w_mode;
  logic [W-1:0]   r_op1;
  logic [W-1:0]   r_op2;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_hilo;
  logic [2*W-1:0] w_hilo_new;
  logic           r_signed;
  logic           w_signed;
  logic           w_is_mul;
  logic           w_launch;
  logic           w_active;
  logic           w_write;

  always_comb begin
    w_is_mul = (op_i >= OP_MULT) && (op_i <= OP_MSUBU);
    w_launch = w_is_mul && !flush_i;
    w_signed = (op_i == OP_MULT) || (op_i == OP_MADD) || (op_i == OP_MSUB);
    w_mode   = ACC_NONE;
    if ((op_i == OP_MADD) || (op_i == OP_MADDU)) w_mode = ACC_ADD;
    if ((op_i == OP_MSUB) || (op_i == OP_MSUBU)) w_mode = ACC_SUB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Start falls in the ready cycle so the multiplier's sequencer drops back to its first state.
  always_comb begin
    w_next     = r_state;
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    w_write    = 1'b0;
    w_active   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          stallreq_o = 1'b1;
          w_next     = S_BUSY;
        end
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        w_active   = 1'b1;
        if (mul.mul_ready) begin
          w_write = !flush_i;
          w_next  = flush_i ? S_IDLE : S_DONE;
        end else if (flush_i) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stallreq_o = 1'b1;
        w_active   = 1'b1;
        if (mul.mul_ready) w_next = S_IDLE;
      end
      S_DONE: begin
        whilo_o = !flush_i;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_mode)
      ACC_ADD: w_hilo_new = r_acc + mul.mul_result;
      ACC_SUB: w_hilo_new = r_acc - mul.mul_result;
      default: w_hilo_new = mul.mul_result;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_acc    <= '0;
      r_signed <= 1'b0;
      r_mode   <= ACC_NONE;
      r_hilo   <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_launch) begin
        r_op1    <= opdata1_i;
        r_op2    <= opdata2_i;
        r_acc    <= {hi_i, lo_i};
        r_signed <= w_signed;
        r_mode   <= w_mode;
      end
      if (w_write) r_hilo <= w_hilo_new;
    end
  end

  assign mul.mul_start  = w_active && !mul.mul_ready;
  assign mul.mul_signed = w_active ? r_signed : 1'b0;
  assign mul.mul_op1    = w_active ? r_op1 : '0;
  assign mul.mul_op2    = w_active ? r_op2 : '0;
  assign hi_o           = r_hilo[2*W-1:W];
  assign lo_o           = r_hilo[W-1:0];
  assign dbg_state_o    = r_state;

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- EX-stage initiator for the 6-cycle HI/LO multiplier; it is the requesting side of the multiplier's start_i/ready_o handshake.
- Decodes MULT/MULTU/MADD/MADDU/MSUB/MSUBU and holds the operands and start stable until the multiplier reports ready.
- Stalls the pipeline while the operation is in flight, applies the MADD/MSUB accumulate, and issues one HI/LO write.
- Absorbs flushes without leaving the multiplier's internal counter mid-sequence.

Parameters:
- W, 32, operand width; HI/LO result is 2*W.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- op_i  in  3  0 none, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 treated as none
- opdata1_i  in  W  rs value
- opdata2_i  in  W  rt value
- hi_i  in  W  current HI, already forwarded
- lo_i  in  W  current LO, already forwarded
- flush_i  in  1  pipeline flush
- mul_signed_o  out  1  signed select to multiplier
- mul_op1_o  out  W  multiplier operand A
- mul_op2_o  out  W  multiplier operand B
- mul_start_o  out  1  multiplier start, combinational
- mul_result_i  in  2W  multiplier product
- mul_ready_i  in  1  multiplier one-cycle ready pulse
- stallreq_o  out  1  stall request to pipeline control, combinational
- whilo_o  out  1  HI/LO write enable, one-cycle pulse
- hi_o  out  W  HI write data
- lo_o  out  W  LO write data

Behaviour:
- Reset (async): state=IDLE, all registers 0; whilo_o=0, hi_o=0, lo_o=0, mul_* outputs=0, stallreq_o=0.
- States: IDLE, BUSY, DRAIN, DONE.
- IDLE:
  - If op_i is 1..6 and flush_i=0: stallreq_o=1 combinationally in the same cycle.
  - At the clock edge, latch op1, op2, {hi_i,lo_i} as acc, the signed flag (MULT/MADD/MSUB), and the accumulate mode (none/add/sub). Next state BUSY.
  - mul_ready_i is ignored in IDLE.
- BUSY:
  - mul_op1_o/mul_op2_o/mul_signed_o driven from the latches, stable for the whole state.
  - mul_start_o = !mul_ready_i. Start drops in the ready cycle so the multiplier returns to its first state and does not begin a second run.
  - stallreq_o=1.
  - op_i, opdata*, hi_i/lo_i are ignored.
- BUSY with mul_ready_i=1 and flush_i=0:
  - Register {hi_o,lo_o} = mul_result_i (mode none), acc+mul_result_i (add), or acc-mul_result_i (sub).
  - Arithmetic is 2W-bit modulo 2^(2W). The product is already in signed or unsigned form per mul_signed_o.
  - Next state DONE.
- BUSY with flush_i=1 and no ready: next state DRAIN.
- BUSY with flush_i=1 and mul_ready_i=1 in the same cycle: result discarded, next state IDLE.
- DRAIN:
  - Same outputs as BUSY (start = !mul_ready_i, stallreq_o=1); flush has priority over stall in pipeline control.
  - On mul_ready_i: result discarded, next state IDLE.
  - The multiplier is therefore always back in its initial state before the next launch.
- DONE:
  - whilo_o=1 for exactly this cycle; stallreq_o=0 and mul_start_o=0.
  - Next state IDLE unconditionally. op_i in DONE belongs to the retiring instruction and is not relaunched.
  - flush_i in DONE suppresses whilo_o.
- Latency: op first visible in cycle T; start high in cycles T+1..T+6; ready in T+7; whilo_o in T+8; pipeline advances at end of T+8.
- hi_o/lo_o hold their last value outside DONE.
- Reset mid-operation returns to IDLE; no write issued. The multiplier shares rst.

Test Plan:
- MULT, op1=FFFFFFFD (-3), op2=00000005 -> start high cycles T+1..T+6, whilo_o at T+8, hi=FFFFFFFF, lo=FFFFFFF1; stallreq high T..T+7.
- MULTU, FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; mul_signed_o=0 throughout BUSY.
- MADD, hi_i=0, lo_i=FFFFFFFF, 2*3 -> hi=00000001, lo=00000005; MSUBU, hi_i=lo_i=0, 1*1 -> hi=lo=FFFFFFFF.
- Flush in BUSY cycle T+3 -> DRAIN, no whilo_o, start drops only in the ready cycle. Then immediate MULT 7*6 -> lo=0000002A, hi=0, normal T+8 timing.
- Back-to-back MULT then MADD -> second launch only after DONE. MADD uses the HI/LO just written (forwarded on hi_i/lo_i), and the multiplier sees exactly 6 start-high edges per operation.
- Async rst asserted mid-BUSY -> all outputs 0 immediately, no whilo_o. The next MULT 2*2 -> lo=4.
